shift_register_bank: RTL and testbench



---
 rtl/shift_register_bank.sv | 109 ++++++++++
 tb/tb_shift_register_bank.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_register_bank.sv
// Bank of nrOfStages gated registers forming a bidirectional shift chain with
// optional parallel load and a saturating fill-level counter.
module shift_register_bank #(
  parameter int unsigned nrOfBits       = 8,
  parameter int unsigned nrOfStages     = 4,
  parameter int unsigned enableParallel = 1
) (
  input  logic                             s_clock,
  input  logic                             reset,
  input  logic                             clockEnable,
  input  logic                             tick,
  input  logic                             load,
  input  logic                             shift,
  input  logic                             dir,
  input  logic [nrOfBits-1:0]              shiftIn,
  input  logic [nrOfBits*nrOfStages-1:0]   parallelIn,
  output logic [nrOfBits-1:0]              shiftOut,
  output logic [nrOfBits*nrOfStages-1:0]   parallelOut,
  output logic [$clog2(nrOfStages+1)-1:0]  fillCount,
  output logic                             full
);

  localparam int unsigned CW      = $clog2(nrOfStages + 1);
  localparam bit          LOAD_EN = (enableParallel != 0);

  logic [nrOfBits-1:0] r_stage [nrOfStages];
  logic [CW-1:0]       r_fill;
  logic                r_full;
  logic                r_dir;

  logic                w_upd;
  logic                w_load;
  logic                w_shift;
  logic [nrOfBits-1:0] w_stage_nxt [nrOfStages];
  logic [CW-1:0]       w_fill_nxt;

  // Qualified update strobes; load wins over shift when parallel load exists.
  assign w_upd   = clockEnable & tick;
  assign w_load  = w_upd & load & LOAD_EN;
  assign w_shift = w_upd & shift & ~w_load;

  // Next-state for the data chain.
  always_comb begin
    for (int unsigned i = 0; i < nrOfStages; i++) begin
      w_stage_nxt[i] = r_stage[i];
    end
    if (w_load) begin
      for (int unsigned i = 0; i < nrOfStages; i++) begin
        w_stage_nxt[i] = parallelIn[i*nrOfBits +: nrOfBits];
      end
    end else if (w_shift) begin
      if (!dir) begin
        w_stage_nxt[0] = shiftIn;
        for (int unsigned i = 1; i < nrOfStages; i++) begin
          w_stage_nxt[i] = r_stage[i-1];
        end
      end else begin
        w_stage_nxt[nrOfStages-1] = shiftIn;
        for (int unsigned i = 0; i < nrOfStages - 1; i++) begin
          w_stage_nxt[i] = r_stage[i+1];
        end
      end
    end
  end

  // Fill level saturates at nrOfStages regardless of shift direction.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_load) begin
      w_fill_nxt = CW'(nrOfStages);
    end else if (w_shift && (r_fill != CW'(nrOfStages))) begin
      w_fill_nxt = r_fill + CW'(1);
    end
  end

  always_ff @(posedge s_clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < nrOfStages; i++) begin
        r_stage[i] <= '0;
      end
      r_fill <= '0;
      r_full <= 1'b0;
      r_dir  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < nrOfStages; i++) begin
        r_stage[i] <= w_stage_nxt[i];
      end
      r_fill <= w_fill_nxt;
      r_full <= (w_fill_nxt == CW'(nrOfStages));
      if (w_upd) begin
        r_dir <= dir;
      end
    end
  end

  // Output end of the chain follows the direction latched on the last update,
  // so no input reaches an output without passing through a register.
  assign shiftOut  = r_dir ? r_stage[0] : r_stage[nrOfStages-1];
  assign fillCount = r_fill;
  assign full      = r_full;

  always_comb begin
    parallelOut = '0;
    for (int unsigned i = 0; i < nrOfStages; i++) begin
      parallelOut[i*nrOfBits +: nrOfBits] = r_stage[i];
    end
  end

endmodule

// File: tb/tb_shift_register_bank.sv
// Scoreboard bench for shift_register_bank: one instance with parallel load,
// one without; expectations queued per edge and checked by a monitor.
module tb_shift_register_bank;

  logic        s_clock = 1'b0;
  logic        reset, clockEnable, tick, load, shift, dir;
  logic        load1, shift1;
  logic [7:0]  shiftIn;
  logic [31:0] parallelIn;
  logic [7:0]  so0, so1;
  logic [31:0] po0, po1;
  logic [2:0]  fc0, fc1;
  logic        fu0, fu1;

  always #5 s_clock = ~s_clock;

  shift_register_bank #(.nrOfBits(8), .nrOfStages(4), .enableParallel(1)) u_dut0 (
    .s_clock(s_clock), .reset(reset), .clockEnable(clockEnable), .tick(tick),
    .load(load), .shift(shift), .dir(dir), .shiftIn(shiftIn), .parallelIn(parallelIn),
    .shiftOut(so0), .parallelOut(po0), .fillCount(fc0), .full(fu0));

  shift_register_bank #(.nrOfBits(8), .nrOfStages(4), .enableParallel(0)) u_dut1 (
    .s_clock(s_clock), .reset(reset), .clockEnable(clockEnable), .tick(tick),
    .load(load1), .shift(shift1), .dir(dir), .shiftIn(shiftIn), .parallelIn(parallelIn),
    .shiftOut(so1), .parallelOut(po1), .fillCount(fc1), .full(fu1));

  typedef struct packed {
    logic [31:0] par;
    logic [7:0]  sout;
    logic [2:0]  fc;
  } exp_t;

  typedef struct packed {
    exp_t d0;
    exp_t d1;
  } entry_t;

  entry_t      sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] gpar [9];
  logic [2:0]  gfc  [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, checked just after the edge.
  always @(posedge s_clock) begin
    #1;
    if (sb_q.size() > 0) begin
      entry_t e;
      e = sb_q.pop_front();
      chk("dut0.parallelOut", po0, e.d0.par);
      chk("dut0.shiftOut",    32'(so0), 32'(e.d0.sout));
      chk("dut0.fillCount",   32'(fc0), 32'(e.d0.fc));
      chk("dut0.full",        32'(fu0), 32'(e.d0.fc == 3'd4));
      chk("dut1.parallelOut", po1, e.d1.par);
      chk("dut1.shiftOut",    32'(so1), 32'(e.d1.sout));
      chk("dut1.fillCount",   32'(fc1), 32'(e.d1.fc));
      chk("dut1.full",        32'(fu1), 32'(e.d1.fc == 3'd4));
    end
  end

  // Drive one edge worth of inputs and queue the state expected after it.
  task automatic step(input logic rst, input logic ce, input logic tk,
                      input logic ld, input logic sh, input logic dr,
                      input logic [7:0] sin, input logic [31:0] pin,
                      input logic [31:0] p0, input logic [7:0] s0, input logic [2:0] f0,
                      input logic ld1 = 1'b0, input logic sh1 = 1'b0,
                      input logic [31:0] p1 = 32'h0, input logic [7:0] s1 = 8'h0,
                      input logic [2:0] f1 = 3'd0);
    entry_t e;
    @(negedge s_clock);
    reset = rst; clockEnable = ce; tick = tk; load = ld; shift = sh; dir = dr;
    load1 = ld1; shift1 = sh1; shiftIn = sin; parallelIn = pin;
    e.d0.par = p0; e.d0.sout = s0; e.d0.fc = f0;
    e.d1.par = p1; e.d1.sout = s1; e.d1.fc = f1;
    sb_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0; clockEnable = 1'b0; tick = 1'b0; load = 1'b0; shift = 1'b0;
    dir = 1'b0; load1 = 1'b0; shift1 = 1'b0; shiftIn = '0; parallelIn = '0;
    gpar = '{32'h0, 32'h0, 32'h12, 32'h12, 32'h12, 32'h1215, 32'h1215, 32'h1215, 32'h121518};
    gfc  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3};

    // Reset, then five edges with shift requested but no tick.
    step(1, 1, 1, 0, 1, 0, 8'h5A, 32'h0, 32'h0, 8'h00, 3'd0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 1, 0, 8'hAB, 32'h0, 32'h0, 8'h00, 3'd0);

    // Serial fill toward higher index, then one extra shift at saturation.
    step(0, 1, 1, 0, 1, 0, 8'h11, 32'h0, 32'h00000011, 8'h00, 3'd1);
    step(0, 1, 1, 0, 1, 0, 8'h22, 32'h0, 32'h00001122, 8'h00, 3'd2);
    step(0, 1, 1, 0, 1, 0, 8'h33, 32'h0, 32'h00112233, 8'h00, 3'd3);
    step(0, 1, 1, 0, 1, 0, 8'h44, 32'h0, 32'h11223344, 8'h11, 3'd4);
    step(0, 1, 1, 0, 1, 0, 8'h55, 32'h0, 32'h22334455, 8'h22, 3'd4);

    // Parallel load, then drain toward lower index.
    step(0, 1, 1, 1, 0, 1, 8'h00, 32'hA1B2C3D4, 32'hA1B2C3D4, 8'hD4, 3'd4);
    step(0, 1, 1, 0, 1, 1, 8'h00, 32'h0, 32'h00A1B2C3, 8'hC3, 3'd4);
    step(0, 1, 1, 0, 1, 1, 8'h00, 32'h0, 32'h0000A1B2, 8'hB2, 3'd4);
    step(0, 1, 1, 0, 1, 1, 8'h00, 32'h0, 32'h000000A1, 8'hA1, 3'd4);

    // Load and shift together: dut0 loads, dut1 (no parallel load) shifts.
    step(0, 1, 1, 1, 1, 0, 8'hFF, 32'h01020304, 32'h01020304, 8'h01, 3'd4,
         1'b1, 1'b1, 32'h000000FF, 8'h00, 3'd1);

    // Gating: tick on every third edge, shift held high.
    step(1, 1, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0, 8'h00, 3'd0);
    for (int k = 0; k < 9; k++)
      step(0, 1, (k % 3 == 2), 0, 1, 0, 8'(8'h10 + k), 32'h0, gpar[k], 8'h00, gfc[k]);
    step(0, 0, 1, 0, 1, 0, 8'h77, 32'h0, 32'h00121518, 8'h00, 3'd3);

    // Reset mid-operation with shift and load also requested.
    step(1, 1, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0, 8'h00, 3'd0);
    step(0, 1, 1, 0, 1, 0, 8'hAA, 32'h0, 32'h000000AA, 8'h00, 3'd1);
    step(0, 1, 1, 0, 1, 0, 8'hBB, 32'h0, 32'h0000AABB, 8'h00, 3'd2);
    step(1, 1, 1, 1, 1, 0, 8'hCC, 32'hDEADBEEF, 32'h0, 8'h00, 3'd0, 1'b1, 1'b1);
    step(0, 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0, 8'h00, 3'd0);

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge s_clock);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
